// File: rtl/fp_align_pipe.sv
// Two-stage exponent compare / mantissa align for the FP adder: stage 1 orders
// operands by effective exponent, stage 2 right-shifts the small mantissa with G/R/S.
module fp_align_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign_a,
  input  logic             in_sign_b,
  input  logic [EXP_W-1:0] in_exp_a,
  input  logic [EXP_W-1:0] in_exp_b,
  input  logic [MAN_W-1:0] in_man_a,
  input  logic [MAN_W-1:0] in_man_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] out_exp,
  output logic [MAN_W:0]   out_man_big,
  output logic [MAN_W:0]   out_man_small,
  output logic             out_guard,
  output logic             out_round,
  output logic             out_sticky,
  output logic             out_sign_big,
  output logic             out_sign_small,
  output logic             out_swapped
);
  localparam int W = MAN_W + 3;

  typedef struct packed {
    logic             signBig;
    logic             signSmall;
    logic             swapped;
    logic [EXP_W-1:0] exp;
    logic [EXP_W-1:0] d;
    logic [MAN_W:0]   manBig;
    logic [MAN_W:0]   manSmall;
  } s1_t;

  logic [2:1]       vldPipe;
  s1_t              s1, s1Nxt;
  logic             s2Adv;
  logic [EXP_W-1:0] effA, effB;
  logic [MAN_W:0]   fullA, fullB;
  logic [W-1:0]     ext, shf, stickyMask;

  // Subnormals use hidden bit 0 and effective exponent 1.
  always_comb begin
    effA  = (in_exp_a == '0) ? EXP_W'(1) : in_exp_a;
    effB  = (in_exp_b == '0) ? EXP_W'(1) : in_exp_b;
    fullA = {in_exp_a != '0, in_man_a};
    fullB = {in_exp_b != '0, in_man_b};
    s1Nxt = '0;
    if (effB > effA) begin
      s1Nxt.swapped   = 1'b1;
      s1Nxt.signBig   = in_sign_b;
      s1Nxt.signSmall = in_sign_a;
      s1Nxt.exp       = effB;
      s1Nxt.d         = effB - effA;
      s1Nxt.manBig    = fullB;
      s1Nxt.manSmall  = fullA;
    end else begin
      s1Nxt.swapped   = 1'b0;
      s1Nxt.signBig   = in_sign_a;
      s1Nxt.signSmall = in_sign_b;
      s1Nxt.exp       = effA;
      s1Nxt.d         = effA - effB;
      s1Nxt.manBig    = fullA;
      s1Nxt.manSmall  = fullB;
    end
  end

  // Shifts of W or more clear the shifted vector and open the mask fully,
  // so the far-shift case needs no separate branch.
  always_comb begin
    ext        = {s1.manSmall, 2'b00};
    shf        = ext >> s1.d;
    stickyMask = ~({W{1'b1}} << s1.d);
  end

  assign s2Adv     = !vldPipe[2] || out_ready;
  assign in_ready  = !vldPipe[1] || s2Adv;
  assign out_valid = vldPipe[2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vldPipe        <= '0;
      s1             <= '0;
      out_exp        <= '0;
      out_man_big    <= '0;
      out_man_small  <= '0;
      out_guard      <= 1'b0;
      out_round      <= 1'b0;
      out_sticky     <= 1'b0;
      out_sign_big   <= 1'b0;
      out_sign_small <= 1'b0;
      out_swapped    <= 1'b0;
    end else begin
      if (in_ready) vldPipe[1] <= in_valid;
      if (in_valid && in_ready) s1 <= s1Nxt;
      if (s2Adv) vldPipe[2] <= vldPipe[1];
      if (s2Adv && vldPipe[1]) begin
        out_exp        <= s1.exp;
        out_man_big    <= s1.manBig;
        out_man_small  <= shf[W-1:2];
        out_guard      <= shf[1];
        out_round      <= shf[0];
        out_sticky     <= |(ext & stickyMask);
        out_sign_big   <= s1.signBig;
        out_sign_small <= s1.signSmall;
        out_swapped    <= s1.swapped;
      end
    end
  end
endmodule

// File: tb/tb_fp_align_pipe.sv
// Scoreboard bench for fp_align_pipe: driver pushes model results on input
// transfer, monitor pops and compares on output transfer.
module tb_fp_align_pipe;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  typedef struct packed {
    logic [7:0]  exp;
    logic [23:0] manBig;
    logic [23:0] manSmall;
    logic        g;
    logic        r;
    logic        s;
    logic        signBig;
    logic        signSmall;
    logic        sw;
  } res_t;

  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic in_sign_a = 0, in_sign_b = 0;
  logic [7:0] in_exp_a = 0, in_exp_b = 0;
  logic [22:0] in_man_a = 0, in_man_b = 0;
  logic [7:0] out_exp;
  logic [23:0] out_man_big, out_man_small;
  logic out_guard, out_round, out_sticky, out_sign_big, out_sign_small, out_swapped;

  always #5 clk = ~clk;

  fp_align_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign_a(in_sign_a), .in_sign_b(in_sign_b), .in_exp_a(in_exp_a), .in_exp_b(in_exp_b),
    .in_man_a(in_man_a), .in_man_b(in_man_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_exp(out_exp), .out_man_big(out_man_big), .out_man_small(out_man_small),
    .out_guard(out_guard), .out_round(out_round), .out_sticky(out_sticky),
    .out_sign_big(out_sign_big), .out_sign_small(out_sign_small), .out_swapped(out_swapped));

  res_t expQ[$];
  res_t got, heldVal;
  int nCmp = 0, nBad = 0, nOut = 0;
  bit readyRand = 0, held = 0;

  always_comb got = {out_exp, out_man_big, out_man_small, out_guard, out_round, out_sticky,
                     out_sign_big, out_sign_small, out_swapped};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    nCmp++;
    if (act !== req) begin
      nBad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: operands as integer significands; the shift is a division and
  // the sticky bit is a nonzero remainder.
  function automatic res_t model(input logic sa, input logic [7:0] ea, input logic [22:0] ma,
                                 input logic sb, input logic [7:0] eb, input logic [22:0] mb);
    int effA, effB, d;
    longint vA, vB, vSmall, e, q;
    res_t res;
    effA = (ea == 0) ? 1 : int'(ea);
    effB = (eb == 0) ? 1 : int'(eb);
    vA = (ea != 0 ? 64'd8388608 : 64'd0) + longint'(ma);
    vB = (eb != 0 ? 64'd8388608 : 64'd0) + longint'(mb);
    res = '0;
    res.sw = effB > effA;
    if (res.sw) begin
      res.exp = 8'(effB); res.manBig = 24'(vB); vSmall = vA; d = effB - effA;
      res.signBig = sb; res.signSmall = sa;
    end else begin
      res.exp = 8'(effA); res.manBig = 24'(vA); vSmall = vB; d = effA - effB;
      res.signBig = sa; res.signSmall = sb;
    end
    e = vSmall * 4;
    if (d >= 26) begin
      res.s = (e != 0);
    end else begin
      q = e / (longint'(1) << d);
      res.manSmall = 24'(q / 4);
      res.g = ((q / 2) % 2) != 0;
      res.r = (q % 2) != 0;
      res.s = (e % (longint'(1) << d)) != 0;
    end
    return res;
  endfunction

  always @(negedge clk)
    if (rst_n && in_valid && in_ready)
      expQ.push_back(model(in_sign_a, in_exp_a, in_man_a, in_sign_b, in_exp_b, in_man_b));

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      nOut++;
      if (expQ.size() == 0) check("unexpected_output", 64'(got), 64'hDEAD);
      else check("result", 64'(got), 64'(expQ.pop_front()));
    end

  always @(negedge clk) begin
    if (rst_n && held) check("stall_hold", {1'b1, got}, {out_valid, heldVal});
    held = rst_n && out_valid && !out_ready;
    heldVal = got;
  end

  always @(posedge clk)
    if (readyRand) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end

  // Starts and ends one time unit after a rising edge.
  task automatic send(input logic sa, input logic [7:0] ea, input logic [22:0] ma,
                      input logic sb, input logic [7:0] eb, input logic [22:0] mb,
                      output int waits);
    in_sign_a = sa; in_exp_a = ea; in_man_a = ma;
    in_sign_b = sb; in_exp_b = eb; in_man_b = mb;
    in_valid = 1; waits = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 200) begin check("in_ready_timeout", 0, 1); break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic sendRnd(output int waits);
    logic [7:0] ea, eb;
    ea = 8'($urandom_range(0, 255));
    case ($urandom_range(0, 4))
      0: eb = 8'($urandom_range(0, 255));
      1: eb = ea + 8'($urandom_range(0, 4));
      2: eb = ea - 8'($urandom_range(0, 30));
      3: eb = 8'd0;
      default: eb = 8'd255;
    endcase
    if ($urandom_range(0, 7) == 0) ea = 0;
    send(1'($urandom), ea, 23'($urandom), 1'($urandom), eb, 23'($urandom), waits);
  endtask

  task automatic drain();
    for (int k = 0; k < 500 && expQ.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    check("drain_empty", 64'(expQ.size()), 0);
  endtask

  initial begin
    int w, wsum, outBase;
    bit sawLow;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 0);
    check("reset_outputs", 64'(got), 0);
    rst_n = 1;
    check("in_ready_after_reset", 64'(in_ready), 1);
    out_ready = 1;

    // Latency: nothing after the accepting edge, result after the next one.
    send(0, 8'd127, 23'h0, 0, 8'd124, 23'h7FFFFF, w);
    @(negedge clk); check("latency_stage1", 64'(out_valid), 0);
    @(negedge clk); check("latency_stage2", 64'(out_valid), 1);
    @(posedge clk); #1;

    // Directed vectors back-to-back: no input stall expected with out_ready=1.
    wsum = 0;
    send(0, 8'd127, 23'h0, 1, 8'd124, 23'h7FFFFF, w); wsum += w;
    send(1, 8'd127, 23'h1, 0, 8'd128, 23'h0, w);      wsum += w;
    send(0, 8'd200, 23'h0, 0, 8'd100, 23'h1, w);      wsum += w;
    send(0, 8'd200, 23'h0, 1, 8'd100, 23'h0, w);      wsum += w;
    send(0, 8'd1, 23'h0, 0, 8'd0, 23'h400000, w);     wsum += w;
    send(1, 8'd0, 23'h123, 0, 8'd0, 23'h7FFFFF, w);   wsum += w;
    send(0, 8'd90, 23'h55AA, 1, 8'd90, 23'h7FFFFF, w); wsum += w;
    send(0, 8'd0, 23'h3, 1, 8'd255, 23'h1234, w);     wsum += w;
    send(0, 8'd150, 23'h7FFFFF, 0, 8'd124, 23'h7FFFFF, w); wsum += w;
    send(0, 8'd150, 23'h7FFFFF, 0, 8'd125, 23'h7FFFFF, w); wsum += w;
    check("back_to_back_waits", 64'(wsum), 0);
    drain();

    // Backpressure: out_ready low for cycles 3-6 while streaming 5 pairs.
    outBase = nOut; sawLow = 0;
    fork
      for (int i = 0; i < 5; i++) sendRnd(w);
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk); if (!in_ready) sawLow = 1;
        @(posedge clk); #1;
        out_ready = !(c >= 3 && c <= 6);
      end
    join
    out_ready = 1;
    drain();
    check("bp_in_ready_dropped", 64'(sawLow), 1);
    check("bp_output_count", 64'(nOut - outBase), 5);

    // Reset with two transactions in flight.
    out_ready = 0;
    sendRnd(w);
    sendRnd(w);
    rst_n = 0;
    @(posedge clk); #1;
    expQ.delete();
    rst_n = 1; out_ready = 1;
    check("midreset_out_valid", 64'(out_valid), 0);
    check("midreset_in_ready", 64'(in_ready), 1);
    outBase = nOut;
    repeat (5) @(posedge clk);
    #1;
    check("midreset_nothing_emitted", 64'(nOut - outBase), 0);

    // Random stream with random backpressure.
    readyRand = 1;
    for (int i = 0; i < 300; i++) begin
      sendRnd(w);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
    readyRand = 0;
    @(posedge clk); #2;
    out_ready = 1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
